// File: rtl/axil_rgmii_init.sv
// AXI-Lite initiator that programs the RGMII/UDP register file after power-on.
// On start_i it writes control (reset=1), port, IP and MAC registers, then
// control (reset=0). It checks param.reg_num and afterwards polls status
// forever, exporting status[0] as crc_err_o.
//
// Ports:
//   clk_i, rst_i           single clock (rgmii.rxc domain), async active-high reset
//   start_i                one-cycle start/restart request
//   busy_o                 write/read sequence in progress (before done_o)
//   done_o                 programming and param check succeeded
//   error_o                sticky: non-OKAY response or param mismatch
//   crc_err_o              status[0] from the last completed poll read
//   m_axil_*               AXI-Lite master channels (AW, W, B, AR, R)
module axil_rgmii_init #(
  parameter int unsigned AXIL_ADDR_WIDTH   = 32,
  parameter int unsigned AXIL_DATA_WIDTH   = 32,
  parameter logic [47:0] FPGA_MAC          = 48'h0,
  parameter logic [47:0] HOST_MAC          = 48'h0,
  parameter logic [31:0] FPGA_IP           = 32'h0,
  parameter logic [31:0] HOST_IP           = 32'h0,
  parameter logic [15:0] FPGA_PORT         = 16'h0,
  parameter logic [15:0] HOST_PORT         = 16'h0,
  parameter logic [10:0] PAYLOAD_BYTES     = 11'd1024,
  parameter logic        CHECK_DESTINATION = 1'b1,
  parameter int unsigned EXP_REG_NUM       = 10,
  parameter int unsigned POLL_CYCLES       = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         crc_err_o,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr_o,
  output logic [2:0]                   m_axil_awprot_o,
  output logic                         m_axil_awvalid_o,
  input  logic                         m_axil_awready_i,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata_o,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb_o,
  output logic                         m_axil_wvalid_o,
  input  logic                         m_axil_wready_i,
  input  logic [1:0]                   m_axil_bresp_i,
  input  logic                         m_axil_bvalid_i,
  output logic                         m_axil_bready_o,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr_o,
  output logic [2:0]                   m_axil_arprot_o,
  output logic                         m_axil_arvalid_o,
  input  logic                         m_axil_arready_i,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata_i,
  input  logic [1:0]                   m_axil_rresp_i,
  input  logic                         m_axil_rvalid_i,
  output logic                         m_axil_rready_o
);

  localparam int unsigned CntW = $clog2(POLL_CYCLES + 1);
  localparam logic [CntW-1:0] PollLast = CntW'(POLL_CYCLES - 1);
  localparam logic [3:0] LastIdx = 4'd8;
  localparam logic [AXIL_ADDR_WIDTH-1:0] ParamAddr  = AXIL_ADDR_WIDTH'(8'h08);
  localparam logic [AXIL_ADDR_WIDTH-1:0] StatusAddr = AXIL_ADDR_WIDTH'(8'h04);
  localparam logic [7:0] ExpRegNum = 8'(EXP_REG_NUM);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StPollWait, StError
  } state_e;

  state_e                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic                         awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                         arvalid_q, arvalid_d;
  logic [AXIL_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         done_q, done_d, error_q, error_d, crc_q, crc_d;
  logic                         restart;
  logic [3:0]                   idx_nxt;

  // Write sequence table: index -> register byte address.
  function automatic logic [AXIL_ADDR_WIDTH-1:0] wr_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd1:    a = 8'h0C;
      4'd2:    a = 8'h10;
      4'd3:    a = 8'h14;
      4'd4:    a = 8'h18;
      4'd5:    a = 8'h1C;
      4'd6:    a = 8'h20;
      4'd7:    a = 8'h24;
      default: a = 8'h00;
    endcase
    return AXIL_ADDR_WIDTH'(a);
  endfunction

  // Write sequence table: index -> data. Index 0 holds the core in reset,
  // index 8 (default) releases it with the same settings.
  function automatic logic [AXIL_DATA_WIDTH-1:0] wr_data(input logic [3:0] idx);
    logic [31:0] d;
    case (idx)
      4'd0:    d = {5'd0, PAYLOAD_BYTES, 14'd0, CHECK_DESTINATION, 1'b1};
      4'd1:    d = {HOST_PORT, FPGA_PORT};
      4'd2:    d = FPGA_IP;
      4'd3:    d = HOST_IP;
      4'd4:    d = FPGA_MAC[31:0];
      4'd5:    d = {16'd0, FPGA_MAC[47:32]};
      4'd6:    d = HOST_MAC[31:0];
      4'd7:    d = {16'd0, HOST_MAC[47:32]};
      default: d = {5'd0, PAYLOAD_BYTES, 14'd0, CHECK_DESTINATION, 1'b0};
    endcase
    return AXIL_DATA_WIDTH'(d);
  endfunction

  assign restart = start_i && (state_q == StIdle || state_q == StPollWait ||
                               state_q == StError);
  assign idx_nxt = idx_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    error_d   = error_q;
    crc_d     = crc_q;
    if (restart) begin
      // Restart wins over the poll counter expiring in the same cycle.
      state_d   = StWrReq;
      idx_d     = 4'd0;
      awaddr_d  = wr_addr(4'd0);
      wdata_d   = wr_data(4'd0);
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end else begin
      unique case (state_q)
        StWrReq: begin
          // AW and W complete independently; leave once both are done.
          if (m_axil_awready_i) awvalid_d = 1'b0;
          if (m_axil_wready_i)  wvalid_d  = 1'b0;
          if (!awvalid_d && !wvalid_d) state_d = StWrResp;
        end
        StWrResp: begin
          if (m_axil_bvalid_i) begin
            if (m_axil_bresp_i != 2'b00) begin
              state_d = StError;
              error_d = 1'b1;
            end else if (idx_q == LastIdx) begin
              state_d   = StRdReq;
              arvalid_d = 1'b1;
              araddr_d  = ParamAddr;
            end else begin
              state_d   = StWrReq;
              idx_d     = idx_nxt;
              awaddr_d  = wr_addr(idx_nxt);
              wdata_d   = wr_data(idx_nxt);
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
            end
          end
        end
        StRdReq: begin
          if (m_axil_arready_i) begin
            arvalid_d = 1'b0;
            state_d   = StRdResp;
          end
        end
        StRdResp: begin
          if (m_axil_rvalid_i) begin
            state_d = StPollWait;
            cnt_d   = '0;
            if (m_axil_rresp_i != 2'b00) begin
              state_d = StError;
              error_d = 1'b1;
            end else if (araddr_q == ParamAddr) begin
              if (m_axil_rdata_i[7:0] != ExpRegNum) begin
                state_d = StError;
                error_d = 1'b1;
              end else begin
                done_d = 1'b1;
              end
            end else begin
              crc_d = m_axil_rdata_i[0];
            end
          end
        end
        StPollWait: begin
          if (cnt_q == PollLast) begin
            state_d   = StRdReq;
            arvalid_d = 1'b1;
            araddr_d  = StatusAddr;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      crc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      error_q   <= error_d;
      crc_q     <= crc_d;
    end
  end

  assign m_axil_awaddr_o  = awaddr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = '1;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = (state_q == StWrResp);
  assign m_axil_araddr_o  = araddr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = (state_q == StRdResp);

  assign busy_o    = !done_q && (state_q == StWrReq || state_q == StWrResp ||
                                 state_q == StRdReq || state_q == StRdResp);
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign crc_err_o = crc_q;

  // Only reg_num and crc_err are consumed from read data.
  logic unused_rdata;
  assign unused_rdata = ^m_axil_rdata_i[AXIL_DATA_WIDTH-1:8];

endmodule

// File: tb/tb_axil_rgmii_init.sv
module tb_axil_rgmii_init;
  localparam int unsigned P     = 8;
  localparam logic [47:0] FMAC  = 48'h0203_0405_0607;
  localparam logic [47:0] HMAC  = 48'h0a0b_0c0d_0e0f;
  localparam logic [31:0] FIP   = 32'hc0a8_0101;
  localparam logic [31:0] HIP   = 32'hc0a8_0102;
  localparam logic [15:0] FPORT = 16'h1234;
  localparam logic [15:0] HPORT = 16'h5678;
  localparam int unsigned EXP   = 10;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, error, crc;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic awvalid, wvalid, arvalid, bready, rready;
  logic awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;

  axil_rgmii_init #(
    .FPGA_MAC(FMAC), .HOST_MAC(HMAC), .FPGA_IP(FIP), .HOST_IP(HIP),
    .FPGA_PORT(FPORT), .HOST_PORT(HPORT), .PAYLOAD_BYTES(11'd1024),
    .CHECK_DESTINATION(1'b1), .EXP_REG_NUM(EXP), .POLL_CYCLES(P)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .error_o(error), .crc_err_o(crc),
    .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready), .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
    .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
    .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready), .m_axil_araddr_o(araddr),
    .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the initiator must do, tracked from bus events.
  typedef enum {PhIdle, PhBusy, PhWait, PhErr} ph_e;
  ph_e ph = PhIdle;
  bit  m_done, m_err, m_crc, rd_first;
  int  wr_idx, poll_left, n_stat, prev_stat;
  int  err_idx = -1, dly = 0, aw_stall = 0;
  logic [7:0]  param_val = 8'd10;
  logic [31:0] exp_addr[9], exp_data[9], obs_data[9];
  logic [31:0] awq[$], wq[$];
  bit          stat_q[$];
  bit   aw_p, w_p, ar_p, b_p, r_p, st_p, aw_h, w_h, ar_h;
  logic [31:0] aw_c, w_c, ar_c, aw_prev, w_prev, ar_prev, a_t, d_t, tmp;
  int   aw_wt, w_wt, ar_wt;

  always @(negedge clk) begin
    if (rst) begin
      ph = PhIdle; m_done = 0; m_err = 0; m_crc = 0; rd_first = 1;
      wr_idx = 0; n_stat = 0; prev_stat = -1;
      awq.delete(); wq.delete();
      {aw_p, w_p, ar_p, b_p, r_p, st_p, aw_h, w_h, ar_h} = '0;
      aw_wt = -1; w_wt = -1; ar_wt = -1;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0;
      chk("rst_ctrl", {busy, done, error, crc, awvalid, wvalid, arvalid, bready, rready}, 0);
      chk("rst_bus", {awaddr, wdata, araddr}, 0);
    end else begin
      // Apply what happened at the previous rising edge.
      if (st_p) begin
        m_done = 0; m_err = 0; wr_idx = 0; rd_first = 1; ph = PhBusy; prev_stat = -1;
        awq.delete(); wq.delete();
      end
      if (b_p) begin
        bvalid = 0;
        if (bresp != 2'b00) begin m_err = 1; ph = PhErr; end
        bresp = 0;
      end
      if (aw_p) begin awready = 0; aw_wt = -1; awq.push_back(aw_c); end
      if (w_p)  begin wready = 0;  w_wt = -1;  wq.push_back(w_c); end
      if (awq.size() > 0 && wq.size() > 0) begin
        a_t = awq.pop_front();
        d_t = wq.pop_front();
        if (wr_idx < 9) begin
          chk("wr_addr", a_t, exp_addr[wr_idx]);
          chk("wr_data", d_t, exp_data[wr_idx]);
          obs_data[wr_idx] = d_t;
        end else chk("wr_count", wr_idx, 8);
        bvalid = 1;
        bresp  = (wr_idx == err_idx) ? 2'b10 : 2'b00;
        wr_idx++;
      end
      if (r_p) begin
        rvalid = 0;
        if (rd_first) begin
          rd_first = 0;
          if (rdata[7:0] != 8'(EXP)) begin m_err = 1; ph = PhErr; end
          else begin m_done = 1; ph = PhWait; poll_left = P; end
        end else begin
          m_crc = rdata[0]; n_stat++; ph = PhWait; poll_left = P;
        end
      end
      if (ar_p) begin
        arready = 0; ar_wt = -1;
        chk("araddr", ar_c, rd_first ? 32'h08 : 32'h04);
        if (!rd_first && dly == 0 && prev_stat >= 0) chk("poll_gap", cyc - prev_stat, P + 2);
        if (!rd_first) prev_stat = cyc;
        tmp = $urandom;
        if (rd_first) tmp[7:0] = param_val;
        else tmp[0] = (stat_q.size() > 0) ? stat_q.pop_front() : 1'($urandom);
        rdata  = tmp;
        rvalid = 1;
      end

      // Compare DUT outputs against the model.
      if (ph == PhWait) begin
        if (poll_left > 0) begin chk("poll_idle", arvalid, 0); poll_left--; end
        else begin chk("poll_read", arvalid, 1); ph = PhBusy; end
      end
      if (ph == PhIdle || ph == PhErr) chk("quiet", {awvalid, wvalid, arvalid}, 0);
      if (st_p) chk("start_wr", {awvalid, wvalid}, 2'b11);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("crc", crc, m_crc);
      chk("busy", busy, (ph == PhBusy) && !m_done);
      if (awvalid) chk("awprot", awprot, 0);
      if (arvalid) chk("arprot", arprot, 0);
      if (wvalid)  chk("wstrb", wstrb, 4'hf);
      if (aw_h && !aw_p) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
      if (w_h && !w_p)   chk("w_stable", {wvalid, wdata}, {1'b1, w_prev});
      if (ar_h && !ar_p) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
      aw_h = awvalid; aw_prev = awaddr;
      w_h  = wvalid;  w_prev  = wdata;
      ar_h = arvalid; ar_prev = araddr;

      // Slave readies with optional random 0-5 cycle delays.
      if (!awvalid) begin awready = 0; aw_wt = -1; end
      else if (!awready && !(aw_stall != 0 && wr_idx == 5)) begin
        if (aw_wt < 0) aw_wt = (dly != 0) ? int'($urandom_range(0, 5)) : 0;
        if (aw_wt == 0) awready = 1; else aw_wt--;
      end
      if (!wvalid) begin wready = 0; w_wt = -1; end
      else if (!wready) begin
        if (w_wt < 0) w_wt = (dly != 0) ? int'($urandom_range(0, 5)) : 0;
        if (w_wt == 0) wready = 1; else w_wt--;
      end
      if (!arvalid) begin arready = 0; ar_wt = -1; end
      else if (!arready) begin
        if (ar_wt < 0) ar_wt = (dly != 0) ? int'($urandom_range(0, 5)) : 0;
        if (ar_wt == 0) arready = 1; else ar_wt--;
      end
      aw_p = awvalid && awready; aw_c = awaddr;
      w_p  = wvalid && wready;   w_c  = wdata;
      ar_p = arvalid && arready; ar_c = araddr;
      b_p  = bvalid && bready;
      r_p  = rvalid && rready;
      st_p = start && (ph != PhBusy);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
  endtask

  int n, ns;

  initial begin
    for (int i = 0; i < 9; i++) exp_addr[i] = (i == 0 || i == 8) ? 32'h0 : 32'(4 * (i + 2));
    exp_data[0] = (32'd1024 << 16) | (32'd1 << 1) | 32'd1;
    exp_data[1] = (32'(HPORT) << 16) | 32'(FPORT);
    exp_data[2] = FIP;
    exp_data[3] = HIP;
    exp_data[4] = 32'(FMAC & 48'hffff_ffff);
    exp_data[5] = 32'(FMAC >> 32);
    exp_data[6] = 32'(HMAC & 48'hffff_ffff);
    exp_data[7] = 32'(HMAC >> 32);
    exp_data[8] = (32'd1024 << 16) | (32'd1 << 1);
    for (int i = 0; i < 9; i++) obs_data[i] = 32'h0;

    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // Zero-wait bring-up, latency and crc sequence.
    stat_q = '{1'b1, 1'b0};
    pulse_start();
    n = 1;
    while (!done && n < 100) begin @(posedge clk); #2; n++; end
    chk("done_latency", n, 21);
    chk("mac_fpga_lo", obs_data[4], 32'h0405_0607);
    chk("mac_fpga_hi", obs_data[5], 32'h0000_0203);
    n = 0;
    while (n_stat < 1 && n < 200) begin @(posedge clk); #2; n++; end
    chk("crc_first", crc, 1);
    while (n_stat < 2 && n < 200) begin @(posedge clk); #2; n++; end
    chk("crc_second", crc, 0);

    // Random ready delays, plus a start while busy that must be ignored.
    dly = 1;
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    n = 0;
    while (!done && n < 500) begin @(posedge clk); #2; n++; end
    chk("rand_done", done, 1);
    chk("rand_writes", wr_idx, 9);

    // Error response on write index 3, then restart.
    dly = 0; err_idx = 3;
    pulse_start();
    n = 0;
    while (!error && n < 100) begin @(posedge clk); #2; n++; end
    repeat (10) @(posedge clk);
    #2;
    chk("berr_error", error, 1);
    chk("berr_writes", wr_idx, 4);
    chk("berr_done", done, 0);
    err_idx = -1; obs_data[0] = 32'h0;
    pulse_start();
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #2; n++; end
    chk("restart_done", done, 1);
    chk("restart_ctrl", obs_data[0], 32'h0400_0003);

    // Param mismatch: error, no done, no polling.
    param_val = 8'd9;
    pulse_start();
    n = 0;
    while (!error && n < 100) begin @(posedge clk); #2; n++; end
    ns = n_stat;
    repeat (3 * P) @(posedge clk);
    #2;
    chk("param_error", error, 1);
    chk("param_done", done, 0);
    chk("param_no_poll", n_stat, ns);
    param_val = 8'd10;

    // Asynchronous reset while awvalid is held at index 5.
    dly = 1; aw_stall = 1;
    pulse_start();
    n = 0;
    while (!(wr_idx == 5 && awvalid) && n < 300) begin @(posedge clk); #2; n++; end
    chk("aw5_held", awvalid, 1);
    rst = 1;
    #1;
    chk("async_rst", {awvalid, wvalid, arvalid, busy, done, error, crc}, 0);
    chk("async_rst_addr", awaddr, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0; aw_stall = 0; dly = 0;
    repeat (20) @(posedge clk);
    #2;
    chk("idle_hold", {awvalid, busy, done}, 0);
    pulse_start();
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #2; n++; end
    chk("post_rst_done", done, 1);
    repeat (2 * P) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axil_rgmii_init.md
# axil_rgmii_init

AXI-Lite initiator that brings up the RGMII/UDP register file after power-on without a CPU. On `start_i` it programs the control, port, IP and MAC registers through a fixed write sequence, checks the parameter register, then polls the status register forever and exports the CRC-error flag. It sits in the `rgmii.rxc` domain, with its `axil_if` master port wired straight to the register file's slave port.

## Interface
- `AXIL_ADDR_WIDTH`, 32: AXI-Lite address width.
- `AXIL_DATA_WIDTH`, 32: AXI-Lite data width; only 32 is supported.
- `FPGA_MAC` / `HOST_MAC`, 48'h0: local and peer MAC addresses.
- `FPGA_IP` / `HOST_IP`, 32'h0: local and peer IPv4 addresses.
- `FPGA_PORT` / `HOST_PORT`, 16'h0: local and peer UDP ports.
- `PAYLOAD_BYTES`, 11'd1024: payload length written into control[26:16].
- `CHECK_DESTINATION`, 1'b1: value written into control[1].
- `EXP_REG_NUM`, 10: expected param[7:0].
- `POLL_CYCLES`, 1024: idle cycles between status reads; minimum 1.
- `clk_i`  in  1  single clock, the `rgmii.rxc` domain.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  one-cycle start/restart request.
- `busy_o`  out  1  high while a write or read sequence runs.
- `done_o`  out  1  high once programming and the param check succeed.
- `error_o`  out  1  high on a non-OKAY response or a param mismatch; sticky.
- `crc_err_o`  out  1  status[0] from the last completed poll read.
- `m_axil`  `axil_if.master`: AXI-Lite master port.

## Operation
- Register map (byte addresses):
  - 0x00 control: [0] reset, [1] check_destination, [26:16] payload_bytes.
  - 0x04 status: [0] crc_err.
  - 0x08 param: [7:0] reg_num.
  - 0x0C port: [31:16] host, [15:0] fpga.
  - 0x10 ip_fpga; 0x14 ip_host.
  - 0x18 / 0x1C mac_fpga lo[31:0] / hi[15:0].
  - 0x20 / 0x24 mac_host lo / hi.
- Write sequence, index 0..8: control with reset=1, 0x0C, 0x10, 0x14, 0x18, 0x1C, 0x20, 0x24, then control with reset=0.
  - Unused high bits are written as 0.
  - `wstrb` is 4'hF on every write.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, POLL_WAIT, ERROR.
- IDLE: on `start_i`, clear `error_o`/`done_o`, set index=0, go to WR_REQ.
- WR_REQ: assert `awvalid` and `wvalid` together.
  - Each valid drops independently on its own ready.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: `bready`=1.
  - On `bvalid` with `bresp`≠0: go to ERROR.
  - Otherwise, if index=8: go to RD_REQ with `araddr`=0x08.
  - Otherwise: index+1, go to WR_REQ.
- RD_REQ: `arvalid` held until `arready`; then go to RD_RESP.
- RD_RESP: `rready`=1. On `rvalid`:
  - `rresp`≠0: go to ERROR.
  - Param read with mismatched reg_num: go to ERROR.
  - Param read that matches: set `done_o`, go to POLL_WAIT.
  - Status read: latch `crc_err_o`=`rdata[0]`, go to POLL_WAIT.
- POLL_WAIT: count `POLL_CYCLES` cycles, then go to RD_REQ with `araddr`=0x04.
- ERROR: all valids low; wait for `start_i`.
- `start_i` is accepted only in IDLE, POLL_WAIT and ERROR; elsewhere it is ignored. Acceptance restarts the sequence at index 0.
- `awprot`/`arprot` are 0.
- `busy_o` = 1 in WR_*/RD_* before `done_o`; it is 0 during poll reads.

## Timing
- Reset values:
  - State IDLE.
  - All valids and readies 0.
  - Addresses and data 0.
  - `busy_o`, `done_o`, `error_o`, `crc_err_o` all 0.
- Reset acts asynchronously mid-transaction: valids drop immediately, and the slave is reset by the same `rst_i`.
- `start_i` in cycle N → `awvalid`/`wvalid` high in cycle N+1.
- `awaddr`/`wdata` are stable while the matching valid is high; `araddr` likewise.
- Valids never depend combinationally on readies.
- Same-cycle `awready`+`wready` completes both handshakes at once.
- `bvalid` already high on WR_RESP entry is accepted on that first cycle.
- With a zero-wait slave, each write is 2 cycles and each read is 2 cycles.
- POLL_WAIT lasts exactly `POLL_CYCLES` cycles; counter width is $clog2(POLL_CYCLES+1).
- `crc_err_o` updates in the cycle after the `rvalid`&`rready` handshake.

## Test plan
- Zero-wait slave, MAC 48'h0203_0405_0607: see nine writes in order, with 0x18=32'h0405_0607 and 0x1C=32'h0000_0203; `done_o` rises 21 cycles after `start_i`.
- Slave inserts random 0-5 cycle ready delays on aw, w and ar independently: same address/data order, `awaddr`/`wdata` stable while valid, no lost handshakes.
- `bresp`=2'b10 on write index 3 → ERROR, `error_o`=1, no further writes; a later `start_i` restarts at 0x00 with reset=1.
- Param read returns reg_num=9 with `EXP_REG_NUM`=10 → `error_o`=1, `done_o`=0, no status polling.
- After `done_o`, status returns 1 then 0 → `crc_err_o` is 1 then 0; consecutive status reads are separated by exactly `POLL_CYCLES`+2 cycles at zero wait.
- `rst_i` pulsed while `awvalid` is high at index 5 → all outputs return to reset values at once; IDLE persists until `start_i`.
